mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Moore FSM sequencing the multicycle MIPS datapath: PC, IR, regfile, ALU, memory, and the
//  branch-offset <<2 path. Decodes opcode/funct and drives the datapath mux selects and write strobes
//  one state per cycle. Handshakes with memory via mem_ready; a bounded wait raises bus_err.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max wait cycles per memory access; 0 = wait forever (no bus_err)
// PORTS
//  clk          in   1  single clock; all state updates on rising edge
//  rst          in   1  synchronous, active-high reset
//  opcode       in   6  IR[31:26]
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU zero flag (valid in BRANCH)
//  mem_ready    in   1  memory access done this cycle
//  pc_we        out  1  PC write strobe
//  pc_src       out  2  0=ALU result, 1=ALUOut (branch target), 2=jump {PC[31:28],IR[25:0],2'b00}
//  iord         out  1  memory address: 0=PC, 1=ALUOut
//  mem_rd/mem_wr out 1  memory read / write request, held until mem_ready
//  ir_we        out  1  IR load
//  reg_we       out  1  regfile write
//  reg_dst      out  2  0=rt, 1=rd, 2=$31
//  mem_to_reg   out  2  0=ALUOut, 1=MDR, 2=PC
//  alu_src_a    out  1  0=PC, 1=A
//  alu_src_b    out  2  0=B, 1=const 4, 2=signext(imm), 3=signext(imm)<<2
//  alu_op       out  3  0=ADD, 1=SUB, 2=FUNCT, 3=AND, 4=OR, 5=SLT
//  state_o      out  4  current state, debug
//  illegal      out  1  sticky: unsupported opcode/funct decoded
//  bus_err      out  1  sticky: memory wait timed out
// BEHAVIOUR
//  Reset: rst wins over all inputs; next edge state=FETCH, wait counter=0, illegal=bus_err=0.
//   While rst=1, pc_we/ir_we/reg_we/mem_wr are forced 0. No other output reset values.
//  FETCH: iord=0, mem_rd=1, srcA=0, srcB=1, ADD, pc_src=0.
//   pc_we=ir_we=mem_ready. Exit to DECODE on mem_ready.
//  DECODE: srcA=0, srcB=3, ADD (branch target precomputed into ALUOut). Dispatch on opcode:
//   00(R, funct in {20,22,24,25,2A})->EXEC_R; 23 lw/2B sw->MEM_ADDR; 04 beq/05 bne->BRANCH;
//   02 j/03 jal->JUMP; 08 addi/0C andi/0D ori/0A slti->EXEC_I; anything else->ILLEGAL.
//  EXEC_R: srcA=1, srcB=0, FUNCT -> ALU_WB. ALU_WB: reg_we, reg_dst=1 (R) / 0 (I), mem_to_reg=0 -> FETCH.
//  EXEC_I: srcA=1, srcB=2, alu_op ADD/AND/OR/SLT by opcode -> ALU_WB.
//  MEM_ADDR: srcA=1, srcB=2, ADD -> MEM_READ (lw) / MEM_WRITE (sw).
//  MEM_READ: iord=1, mem_rd=1; on mem_ready -> MEM_WB. MEM_WB: reg_we, reg_dst=0, mem_to_reg=1 -> FETCH.
//  MEM_WRITE: iord=1, mem_wr=1; on mem_ready -> FETCH.
//  BRANCH: srcA=1, srcB=0, SUB, pc_src=1, pc_we = zero^(opcode==05) -> FETCH.
//  JUMP: pc_src=2, pc_we=1; jal also reg_we, reg_dst=2, mem_to_reg=2 (PC already holds PC+4) -> FETCH.
//  Latency with mem_ready=1: beq/bne/j/jal 3 cycles; R/I-ALU/sw 4 cycles; lw 5 cycles.
//   Each cycle mem_ready=0 in a memory state adds one cycle.
//  Timeout: counter cleared on entering FETCH/MEM_READ/MEM_WRITE; increments per cycle with mem_ready=0.
//   When count==TIMEOUT_CYCLES-1 and mem_ready=0 -> ERR. mem_ready in that same cycle wins (normal advance).
//  ILLEGAL / ERR: terminal until rst. All strobes and requests 0; set illegal / bus_err respectively.
//  Unlisted outputs are 0 in every state. Outputs are combinational from state (plus zero, mem_ready, opcode).
// STRUCTURE
//  Package mips_ctrl_defs: opcode/funct localparams, state encodings (4-bit), alu_op, pc_src, reg_dst,
//   mem_to_reg codes.
//  Sub-module mips_ctrl_wait_timer: clear/inc counter with timeout flag.
// TESTING
//  add (op 00, funct 20), mem_ready=1 -> FETCH,DECODE,EXEC_R,ALU_WB; reg_we=1 reg_dst=1 in cycle 4 only.
//  lw, mem_ready low 3 cycles in MEM_READ -> mem_rd,iord held 3 extra cycles; MEM_WB reg_we, mem_to_reg=1.
//  beq zero=1 -> pc_we=1 pc_src=1 in BRANCH; bne zero=1 -> pc_we=0; both back to FETCH in cycle 4.
//  jal -> JUMP cycle: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, mem_to_reg=2.
//  opcode 3F -> ILLEGAL after DECODE, illegal=1, all strobes 0; rst pulse -> FETCH, illegal=0.
//  TIMEOUT_CYCLES=4, mem_ready=0 in FETCH -> bus_err after 4 cycles; rst in MEM_WRITE -> mem_wr=0 same cycle.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, functs,
// state encodings and the datapath select codes.
package mips_ctrl_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ILLEGAL   = 4'd11,
    S_ERR       = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_FUNCT = 3'd2,
    ALU_AND   = 3'd3,
    ALU_OR    = 3'd4,
    ALU_SLT   = 3'd5
  } alu_op_e;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  function automatic logic funct_supported(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_supported = 1'b1;
      default:                               funct_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_we;
  logic       reg_we;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state_o;
  logic       illegal;
  logic       bus_err;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, pc_src, iord, mem_rd, mem_wr, ir_we, reg_we, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, state_o, illegal, bus_err
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, pc_src, iord, mem_rd, mem_wr, ir_we, reg_we, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, state_o, illegal, bus_err
  );
endinterface

// File: rtl/mips_multicycle_ctrl_wait_timer.sv
// Memory wait counter: clears on state entry, counts not-ready cycles and
// flags the last allowed wait cycle. TIMEOUT_CYCLES=0 never flags.
module mips_ctrl_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic timeout_o
);
  localparam int              CW   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam bit              EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = EN && (cnt_q == LAST);
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore controller for the multicycle MIPS datapath, one state per cycle,
// with bounded memory waits and terminal ILLEGAL/ERR states.
module mips_multicycle_ctrl
  import mips_ctrl_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  mips_multicycle_ctrl_if.master bus
);
  state_e state_q, state_d;
  logic   wait_timeout;
  logic   pc_we_raw, ir_we_raw, reg_we_raw, mem_wr_raw;

  mips_ctrl_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_d != state_q),
    .inc_i     (!bus.mem_ready),
    .timeout_o (wait_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_we_raw      = 1'b0;
    ir_we_raw      = 1'b0;
    reg_we_raw     = 1'b0;
    mem_wr_raw     = 1'b0;
    bus.pc_src     = PC_SRC_ALU;
    bus.iord       = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.reg_dst    = REG_DST_RT;
    bus.mem_to_reg = M2R_ALUOUT;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_B;
    bus.alu_op     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        bus.mem_rd    = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        pc_we_raw     = bus.mem_ready;
        ir_we_raw     = bus.mem_ready;
        if (bus.mem_ready)     state_d = S_DECODE;
        else if (wait_timeout) state_d = S_ERR;
        else                   state_d = S_FETCH;
      end
      S_DECODE: begin
        bus.alu_src_b = SRCB_IMM_SH;
        case (bus.opcode)
          OP_RTYPE:                      state_d = funct_supported(bus.funct) ? S_EXEC_R : S_ILLEGAL;
          OP_LW, OP_SW:                  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                state_d = S_BRANCH;
          OP_J, OP_JAL:                  state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
          default:                       state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
        state_d       = S_ALU_WB;
      end
      S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        case (bus.opcode)
          OP_ANDI: bus.alu_op = ALU_AND;
          OP_ORI:  bus.alu_op = ALU_OR;
          OP_SLTI: bus.alu_op = ALU_SLT;
          default: bus.alu_op = ALU_ADD;
        endcase
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_we_raw  = 1'b1;
        bus.reg_dst = (bus.opcode == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        state_d       = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        bus.iord   = 1'b1;
        bus.mem_rd = 1'b1;
        if (bus.mem_ready)     state_d = S_MEM_WB;
        else if (wait_timeout) state_d = S_ERR;
        else                   state_d = S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_we_raw     = 1'b1;
        bus.mem_to_reg = M2R_MDR;
        state_d        = S_FETCH;
      end
      S_MEM_WRITE: begin
        bus.iord   = 1'b1;
        mem_wr_raw = 1'b1;
        if (bus.mem_ready)     state_d = S_FETCH;
        else if (wait_timeout) state_d = S_ERR;
        else                   state_d = S_MEM_WRITE;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = PC_SRC_ALUOUT;
        pc_we_raw     = bus.zero ^ (bus.opcode == OP_BNE);
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        // PC already holds PC+4, so jal links straight from the PC
        bus.pc_src     = PC_SRC_JUMP;
        pc_we_raw      = 1'b1;
        reg_we_raw     = (bus.opcode == OP_JAL);
        bus.reg_dst    = (bus.opcode == OP_JAL) ? REG_DST_RA : REG_DST_RT;
        bus.mem_to_reg = (bus.opcode == OP_JAL) ? M2R_PC : M2R_ALUOUT;
        state_d        = S_FETCH;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      S_ERR:     state_d = S_ERR;
      default:   state_d = S_FETCH;
    endcase
  end

  assign bus.pc_we   = pc_we_raw  && !rst;
  assign bus.ir_we   = ir_we_raw  && !rst;
  assign bus.reg_we  = reg_we_raw && !rst;
  assign bus.mem_wr  = mem_wr_raw && !rst;
  assign bus.state_o = state_q;
  assign bus.illegal = (state_q == S_ILLEGAL);
  assign bus.bus_err = (state_q == S_ERR);
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed + randomized bench: each instruction expands into its expected
// per-cycle output sequence, replayed against the controller.
module tb_mips_multicycle_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus();
  mips_multicycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       iord, mem_rd, mem_wr, ir_we, reg_we;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal, bus_err;
  } outs_t;

  typedef struct {
    logic [5:0] op, fn;
    logic       z, rdy;
    outs_t      e;
    string      tag;
  } cyc_t;

  cyc_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic outs_t observe();
    outs_t o;
    o.pc_we = bus.pc_we;   o.pc_src = bus.pc_src;   o.iord = bus.iord;
    o.mem_rd = bus.mem_rd; o.mem_wr = bus.mem_wr;   o.ir_we = bus.ir_we;
    o.reg_we = bus.reg_we; o.reg_dst = bus.reg_dst; o.mem_to_reg = bus.mem_to_reg;
    o.alu_src_a = bus.alu_src_a; o.alu_src_b = bus.alu_src_b; o.alu_op = bus.alu_op;
    o.illegal = bus.illegal; o.bus_err = bus.bus_err;
    return o;
  endfunction

  // Expected outputs per datapath step, straight from the control table
  function automatic outs_t e_fetch(input logic r);
    outs_t e = '0; e.mem_rd = 1'b1; e.alu_src_b = 2'd1; e.pc_we = r; e.ir_we = r; return e;
  endfunction
  function automatic outs_t e_decode();
    outs_t e = '0; e.alu_src_b = 2'd3; return e;
  endfunction
  function automatic outs_t e_exec(input logic [5:0] op);
    outs_t e = '0; e.alu_src_a = 1'b1;
    case (op)
      6'h00:   e.alu_op = 3'd2;
      6'h0C:   e.alu_op = 3'd3;
      6'h0D:   e.alu_op = 3'd4;
      6'h0A:   e.alu_op = 3'd5;
      default: e.alu_op = 3'd0;
    endcase
    e.alu_src_b = (op == 6'h00) ? 2'd0 : 2'd2;
    return e;
  endfunction
  function automatic outs_t e_wb(input logic is_r);
    outs_t e = '0; e.reg_we = 1'b1; e.reg_dst = is_r ? 2'd1 : 2'd0; return e;
  endfunction
  function automatic outs_t e_addr();
    outs_t e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; return e;
  endfunction
  function automatic outs_t e_mem(input logic wr);
    outs_t e = '0; e.iord = 1'b1; e.mem_rd = !wr; e.mem_wr = wr; return e;
  endfunction
  function automatic outs_t e_memwb();
    outs_t e = '0; e.reg_we = 1'b1; e.mem_to_reg = 2'd1; return e;
  endfunction
  function automatic outs_t e_branch(input logic is_bne, input logic z);
    outs_t e = '0; e.alu_src_a = 1'b1; e.alu_op = 3'd1; e.pc_src = 2'd1;
    e.pc_we = is_bne ? !z : z; return e;
  endfunction
  function automatic outs_t e_jump(input logic link);
    outs_t e = '0; e.pc_src = 2'd2; e.pc_we = 1'b1;
    if (link) begin e.reg_we = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; end
    return e;
  endfunction
  function automatic outs_t e_term(input logic is_err);
    outs_t e = '0; e.bus_err = is_err; e.illegal = !is_err; return e;
  endfunction

  function automatic void push(input logic [5:0] op, fn, input logic z, r, input outs_t e, input string tag);
    cyc_t c;
    c.op = op; c.fn = fn; c.z = z; c.rdy = r; c.e = e; c.tag = tag;
    q.push_back(c);
  endfunction

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its cycle sequence; fs/ms = not-ready cycles in fetch/memory
  task automatic add_instr(input logic [5:0] op, fn, input logic z, input int fs, ms, input string nm);
    logic legal_r;
    legal_r = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int i = 0; i < fs && i < TO; i++) push(op, fn, z, 1'b0, e_fetch(1'b0), {nm, "/fetch_wait"});
    if (fs >= TO) begin
      push(op, fn, z, rnd(), e_term(1'b1), {nm, "/fetch_timeout"});
      push(op, fn, z, rnd(), e_term(1'b1), {nm, "/err_hold"});
      return;
    end
    push(op, fn, z, 1'b1, e_fetch(1'b1), {nm, "/fetch"});
    push(op, fn, z, rnd(), e_decode(), {nm, "/decode"});
    case (op)
      6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A: begin
        if (op == 6'h00 && !legal_r) begin
          for (int i = 0; i < 3; i++) push(op, fn, z, rnd(), e_term(1'b0), {nm, "/illegal"});
        end else begin
          push(op, fn, z, rnd(), e_exec(op), {nm, "/exec"});
          push(op, fn, z, rnd(), e_wb(op == 6'h00), {nm, "/alu_wb"});
        end
      end
      6'h23, 6'h2B: begin
        push(op, fn, z, rnd(), e_addr(), {nm, "/mem_addr"});
        for (int i = 0; i < ms && i < TO; i++) push(op, fn, z, 1'b0, e_mem(op == 6'h2B), {nm, "/mem_wait"});
        if (ms >= TO) begin
          push(op, fn, z, rnd(), e_term(1'b1), {nm, "/mem_timeout"});
          push(op, fn, z, rnd(), e_term(1'b1), {nm, "/err_hold"});
          return;
        end
        push(op, fn, z, 1'b1, e_mem(op == 6'h2B), {nm, "/mem_done"});
        if (op == 6'h23) push(op, fn, z, rnd(), e_memwb(), {nm, "/mem_wb"});
      end
      6'h04, 6'h05: push(op, fn, z, rnd(), e_branch(op == 6'h05, z), {nm, "/branch"});
      6'h02, 6'h03: push(op, fn, z, rnd(), e_jump(op == 6'h03), {nm, "/jump"});
      default: for (int i = 0; i < 3; i++) push(op, fn, z, rnd(), e_term(1'b0), {nm, "/illegal"});
    endcase
  endtask

  task automatic run_q();
    cyc_t  c;
    outs_t obs;
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.opcode = c.op; bus.funct = c.fn; bus.zero = c.z; bus.mem_ready = c.rdy;
      @(negedge clk);
      obs = observe();
      checks++;
      assert (obs === c.e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", c.tag, obs, c.e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input string tag);
    logic [3:0] strobes;
    rst = 1'b1; bus.mem_ready = 1'b1;
    @(negedge clk);
    strobes = {bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_wr};
    checks++;
    assert (strobes === 4'b0000) else begin
      errors++;
      $error("FAIL %s strobes observed=%b expected=0000", tag, strobes);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pick(input int sel, output logic [5:0] op, output logic [5:0] fn);
    logic [5:0] fns [5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    fn = 6'($urandom);
    case (sel)
      0, 1, 2, 3, 4: begin op = 6'h00; fn = fns[sel]; end
      5:  op = 6'h23;
      6:  op = 6'h2B;
      7:  op = 6'h04;
      8:  op = 6'h05;
      9:  op = 6'h02;
      10: op = 6'h03;
      11: op = 6'h08;
      12: op = 6'h0C;
      13: op = 6'h0D;
      default: op = 6'h0A;
    endcase
  endtask

  initial begin
    logic [5:0] op, fn;
    outs_t      obs;
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    do_reset("reset_initial");

    add_instr(6'h00, 6'h20, 1'b0, 0, 0, "add");
    add_instr(6'h23, 6'h00, 1'b0, 0, 3, "lw_stall3");
    add_instr(6'h04, 6'h00, 1'b1, 0, 0, "beq_taken");
    add_instr(6'h05, 6'h00, 1'b1, 0, 0, "bne_not_taken");
    add_instr(6'h03, 6'h00, 1'b0, 3, 0, "jal_fetch_stall3");
    add_instr(6'h2B, 6'h00, 1'b0, 0, 2, "sw_stall2");
    run_q();

    for (int k = 0; k < 40; k++) begin
      pick($urandom_range(0, 14), op, fn);
      add_instr(op, fn, rnd(), $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end
    run_q();

    add_instr(6'h3F, 6'h00, 1'b0, 0, 0, "op3f");
    run_q();
    do_reset("reset_from_illegal");
    add_instr(6'h02, 6'h00, 1'b0, 0, 0, "j_after_illegal");
    add_instr(6'h00, 6'h21, 1'b0, 1, 0, "bad_funct");
    run_q();
    do_reset("reset_from_bad_funct");

    add_instr(6'h00, 6'h2A, 1'b0, TO, 0, "fetch_timeout");
    run_q();
    do_reset("reset_from_err");
    add_instr(6'h23, 6'h00, 1'b0, 0, TO, "lw_timeout");
    run_q();
    do_reset("reset_from_mem_err");

    // Park in MEM_WRITE, then reset while the write request is up
    push(6'h2B, 6'h00, 1'b0, 1'b1, e_fetch(1'b1), "sw_rst/fetch");
    push(6'h2B, 6'h00, 1'b0, 1'b0, e_decode(), "sw_rst/decode");
    push(6'h2B, 6'h00, 1'b0, 1'b0, e_addr(), "sw_rst/mem_addr");
    push(6'h2B, 6'h00, 1'b0, 1'b0, e_mem(1'b1), "sw_rst/mem_wait");
    run_q();
    rst = 1'b1; bus.mem_ready = 1'b0;
    @(negedge clk);
    obs = observe();
    checks++;
    assert ({obs.mem_wr, obs.pc_we, obs.ir_we, obs.reg_we, obs.iord} === 5'b00001) else begin
      errors++;
      $error("FAIL rst_in_mem_write observed=%b expected=00001",
             {obs.mem_wr, obs.pc_we, obs.ir_we, obs.reg_we, obs.iord});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    add_instr(6'h0D, 6'h00, 1'b0, 0, 0, "ori_after_rst");
    run_q();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
